// File: rtl/riscv_csr_unit.sv
// Zicsr / ECALL sequencing stage in front of a single-port CSR file.
// One instruction per request: read-modify-write, or the trap-entry sequence.
module riscv_csr_unit #(
    parameter int unsigned WORD_LENGTH = 32,
    parameter int unsigned CSR_ADDR_W  = 12,
    parameter logic [CSR_ADDR_W-1:0] MTVEC_ADDR  = 12'h305,
    parameter logic [CSR_ADDR_W-1:0] MEPC_ADDR   = 12'h341,
    parameter logic [CSR_ADDR_W-1:0] MCAUSE_ADDR = 12'h342,
    parameter logic [WORD_LENGTH-1:0] ECALL_CAUSE = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_funct3,
    input  logic [CSR_ADDR_W-1:0]  req_addr,
    input  logic [WORD_LENGTH-1:0] req_rs1_val,
    input  logic [4:0]             req_rs1_idx,
    input  logic [WORD_LENGTH-1:0] req_pc,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [WORD_LENGTH-1:0] resp_data,
    output logic                   resp_trap,
    output logic                   resp_illegal,
    output logic [CSR_ADDR_W-1:0]  csr_addr,
    output logic [WORD_LENGTH-1:0] csr_wdata,
    output logic                   csr_we,
    input  logic [WORD_LENGTH-1:0] csr_rdata
);

    typedef enum logic [2:0] {
        IDLE, READ, WRITE, T_EPC, T_CAUSE, T_VEC, DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             funct3_q, funct3_d;
    logic [CSR_ADDR_W-1:0]  addr_q, addr_d;
    logic [WORD_LENGTH-1:0] rs1_val_q, rs1_val_d;
    logic [4:0]             rs1_idx_q, rs1_idx_d;
    logic [WORD_LENGTH-1:0] pc_q, pc_d;
    logic [WORD_LENGTH-1:0] data_q, data_d;
    logic                   trap_q, trap_d;
    logic                   illegal_q, illegal_d;

    logic [WORD_LENGTH-1:0] src;
    logic [WORD_LENGTH-1:0] new_val;
    logic                   wr_skip;
    logic                   accept;

    assign req_ready    = (state_q == IDLE);
    assign accept       = req_valid && req_ready;
    assign resp_valid   = (state_q == DONE);
    assign resp_data    = data_q;
    assign resp_trap    = trap_q;
    assign resp_illegal = illegal_q;

    // data_q holds the old CSR value from READ onward
    always_comb begin
        src = funct3_q[2] ? {{(WORD_LENGTH-5){1'b0}}, rs1_idx_q} : rs1_val_q;
        unique case (funct3_q[1:0])
            2'b10:   new_val = data_q | src;
            2'b11:   new_val = data_q & ~src;
            default: new_val = src;
        endcase
        wr_skip = funct3_q[1] && (rs1_idx_q == 5'd0);
    end

    always_comb begin
        state_d   = state_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        rs1_val_d = rs1_val_q;
        rs1_idx_d = rs1_idx_q;
        pc_d      = pc_q;
        data_d    = data_q;
        trap_d    = trap_q;
        illegal_d = illegal_q;
        csr_addr  = '0;
        csr_wdata = '0;
        csr_we    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    funct3_d  = req_funct3;
                    addr_d    = req_addr;
                    rs1_val_d = req_rs1_val;
                    rs1_idx_d = req_rs1_idx;
                    pc_d      = req_pc;
                    data_d    = '0;
                    trap_d    = 1'b0;
                    illegal_d = 1'b0;
                    if (req_funct3 == 3'b000) begin
                        state_d = T_EPC;
                    end else if (req_funct3 == 3'b100) begin
                        state_d   = DONE;
                        illegal_d = 1'b1;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                csr_addr = addr_q;
                data_d   = csr_rdata;
                state_d  = wr_skip ? DONE : WRITE;
            end
            WRITE: begin
                csr_addr  = addr_q;
                csr_we    = 1'b1;
                csr_wdata = new_val;
                state_d   = DONE;
            end
            T_EPC: begin
                csr_addr  = MEPC_ADDR;
                csr_we    = 1'b1;
                csr_wdata = pc_q;
                state_d   = T_CAUSE;
            end
            T_CAUSE: begin
                csr_addr  = MCAUSE_ADDR;
                csr_we    = 1'b1;
                csr_wdata = ECALL_CAUSE;
                state_d   = T_VEC;
            end
            T_VEC: begin
                // direct mode: mode bits dropped from the vector
                csr_addr = MTVEC_ADDR;
                data_d   = {csr_rdata[WORD_LENGTH-1:2], 2'b00};
                trap_d   = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            funct3_q  <= '0;
            addr_q    <= '0;
            rs1_val_q <= '0;
            rs1_idx_q <= '0;
            pc_q      <= '0;
            data_q    <= '0;
            trap_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            funct3_q  <= funct3_d;
            addr_q    <= addr_d;
            rs1_val_q <= rs1_val_d;
            rs1_idx_q <= rs1_idx_d;
            pc_q      <= pc_d;
            data_q    <= data_d;
            trap_q    <= trap_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_riscv_csr_unit.sv
// Bench for riscv_csr_unit: directed cases then random ops,
// checked against an instruction-level model of the CSR file.
module tb_riscv_csr_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic [31:0] req_rs1_val;
    logic [4:0]  req_rs1_idx;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_trap;
    logic        resp_illegal;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_we;
    logic [31:0] csr_rdata;

    riscv_csr_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_funct3(req_funct3), .req_addr(req_addr),
        .req_rs1_val(req_rs1_val), .req_rs1_idx(req_rs1_idx),
        .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_trap(resp_trap),
        .resp_illegal(resp_illegal),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_we(csr_we), .csr_rdata(csr_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:4095];
    logic [43:0] wlog [$];
    logic        pl_we = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [31:0] pl_data = '0;
    int          n_tests = 0;
    int          n_fail = 0;

    assign csr_rdata = mem[csr_addr];

    always @(posedge clk) begin
        if (csr_we) begin
            mem[csr_addr] <= csr_wdata;
            wlog.push_back({csr_addr, csr_wdata});
        end else if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk);
        #1 pl_we = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [11:0] a,
                          input logic [31:0] v, input logic [4:0] ix,
                          input logic [31:0] pc, input int bp);
        logic [31:0] old, src, nv, exp_data, hold;
        logic        exp_trap, exp_ill;
        int          exp_lat, lat;
        logic [43:0] exp_w [$];
        exp_w = {};
        exp_trap = 1'b0;
        exp_ill = 1'b0;
        if (f3 == 3'b000) begin
            exp_data = mem[12'h305] & 32'hFFFF_FFFC;
            exp_trap = 1'b1;
            exp_lat = 4;
            exp_w.push_back({12'h341, pc});
            exp_w.push_back({12'h342, 32'd11});
        end else if (f3 == 3'b100) begin
            exp_data = 0;
            exp_ill = 1'b1;
            exp_lat = 1;
        end else begin
            old = mem[a];
            src = f3[2] ? 32'(ix) : v;
            if (f3[1:0] == 2'b01) nv = src;
            else if (f3[1:0] == 2'b10) nv = old | src;
            else nv = old & ~src;
            exp_data = old;
            if (f3[1:0] == 2'b01 || ix != 0) begin
                exp_lat = 3;
                exp_w.push_back({a, nv});
            end else begin
                exp_lat = 2;
            end
        end
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 1);
        req_valid = 1'b1; req_funct3 = f3; req_addr = a;
        req_rs1_val = v; req_rs1_idx = ix; req_pc = pc;
        wlog = {};
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_funct3 = 3'($urandom); req_addr = 12'($urandom);
        req_rs1_val = $urandom; req_rs1_idx = 5'($urandom);
        req_pc = $urandom;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("resp_data", resp_data, exp_data);
        chk("resp_trap", 32'(resp_trap), 32'(exp_trap));
        chk("resp_illegal", 32'(resp_illegal), 32'(exp_ill));
        hold = resp_data;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(resp_valid), 1);
            chk("bp_data", resp_data, hold);
            chk("bp_req_ready", 32'(req_ready), 0);
            chk("bp_we", 32'(csr_we), 0);
            chk("bp_addr", 32'(csr_addr), 0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        chk("post_valid", 32'(resp_valid), 0);
        chk("post_req_ready", 32'(req_ready), 1);
        chk("wr_count", 32'(wlog.size()), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < wlog.size(); i++) begin
            chk("wr_addr", 32'(wlog[i][43:32]), 32'(exp_w[i][43:32]));
            chk("wr_data", wlog[i][31:0], exp_w[i][31:0]);
        end
    endtask

    logic [11:0] addrs [6] = '{12'h300, 12'h305, 12'h340,
                               12'h341, 12'h342, 12'h304};

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_funct3 = '0; req_addr = '0; req_rs1_val = '0;
        req_rs1_idx = '0; req_pc = '0;
        for (int i = 0; i < 6; i++) poke(addrs[i], $urandom);
        #1;
        chk("rst_valid", 32'(resp_valid), 0);
        chk("rst_data", resp_data, 0);
        chk("rst_we", 32'(csr_we), 0);
        chk("rst_addr", 32'(csr_addr), 0);
        chk("rst_wdata", csr_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 1);

        poke(12'h300, 32'hAAAA_0000);
        run_op(3'b001, 12'h300, 32'h1234_5678, 5'd7, 0, 0);
        chk("rw_file", mem[12'h300], 32'h1234_5678);
        poke(12'h300, 32'h5);
        run_op(3'b010, 12'h300, 32'hFFFF_FFFF, 5'd0, 0, 0);
        poke(12'h300, 32'hF);
        run_op(3'b111, 12'h300, 32'h0, 5'd3, 0, 0);
        chk("rci_file", mem[12'h300], 32'hC);
        poke(12'h305, 32'h107);
        run_op(3'b000, 12'h000, 32'h0, 5'd0, 32'h80, 0);
        chk("ecall_target", resp_data, 32'h104);
        run_op(3'b001, 12'h304, 32'h55, 5'd1, 0, 5);
        run_op(3'b100, 12'h300, 32'h99, 5'd4, 0, 0);

        poke(12'h342, 32'hDEAD_BEEF);
        poke(12'h341, 32'h0);
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = 3'b000; req_pc = 32'h80;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("tcause_we", 32'(csr_we), 1);
        chk("tcause_addr", 32'(csr_addr), 32'h342);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(resp_valid), 0);
        chk("mid_rst_trap", 32'(resp_trap), 0);
        chk("mid_rst_we", 32'(csr_we), 0);
        chk("mid_rst_addr", 32'(csr_addr), 0);
        chk("mid_rst_wdata", csr_wdata, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 32'(req_ready), 1);
        chk("mcause_kept", mem[12'h342], 32'hDEAD_BEEF);
        chk("mepc_kept", mem[12'h341], 32'h80);

        for (int n = 0; n < 200; n++) begin
            logic [4:0] ix;
            ix = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            run_op(3'($urandom), addrs[$urandom_range(0, 5)], $urandom,
                   ix, $urandom, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
